// File: rtl/pattern_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_bist_ctrl
// Description : Exhaustive-pattern BIST controller for a small gate. It walks
//               every PAT_W-bit input pattern, waits SETTLE cycles, captures
//               the gate's {enable, masked data} response into a MISR and
//               compares the final signature against GOLDEN.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_bist_ctrl #(
  parameter int               PAT_W  = 2,
  parameter int               SETTLE = 1,
  parameter int               SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = 8'h1D,
  parameter logic [SIG_W-1:0] GOLDEN = 8'h1C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [PAT_W-1:0] pattin,
  input  logic             dut_out,
  input  logic             dut_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [PAT_W:0]   pat_count
);

  // State encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_APPLY   = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Settle down-counter sized to hold SETTLE; at least one bit so that the
  // SETTLE == 0 build still has a legal (unused) register.
  localparam int               CNT_W     = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
  localparam logic [PAT_W-1:0] IDX_LAST  = '1;

  logic [2:0]       state_q,  state_d;
  logic [PAT_W-1:0] idx_q,    idx_d;
  logic [PAT_W-1:0] pattin_q, pattin_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [SIG_W-1:0] sig_q,    sig_d;
  logic [PAT_W:0]   npat_q,   npat_d;
  logic             pass_q,   pass_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [SIG_W-1:0] resp_w;
  logic [SIG_W-1:0] sig_next_w;

  // Response word and MISR step: shift, fold in POLY on carry-out, xor response.
  // A high-Z gate forces both response bits to 0 regardless of dut_out.
  always_comb begin
    resp_w     = {{(SIG_W-2){1'b0}}, dut_en, dut_en & dut_out};
    sig_next_w = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
               ^ resp_w;
  end

  // Next-state and datapath update for the pattern walk.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pattin_d = pattin_q;
    cnt_d    = cnt_q;
    sig_d    = sig_q;
    npat_d   = npat_q;
    pass_d   = pass_q;

    case (state_q)
      ST_IDLE: begin
        pattin_d = '0;
        if (start) begin
          state_d = ST_APPLY;
          idx_d   = '0;
          sig_d   = '0;
          npat_d  = '0;
          pass_d  = 1'b0;
        end
      end

      ST_APPLY: begin
        pattin_d = idx_q;
        if (SETTLE == 0) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end

      ST_SETTLE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end

      ST_CAPTURE: begin
        sig_d  = sig_next_w;
        npat_d = npat_q + (PAT_W+1)'(1);
        if (idx_q == IDX_LAST) begin
          // Last pattern: stop here so the index never wraps within a run.
          state_d  = ST_DONE;
          pattin_d = '0;
        end else begin
          // Next pattern loads into the pattin register on the same edge,
          // so the gate input steps directly from one index to the next.
          state_d  = ST_APPLY;
          idx_d    = idx_q + PAT_W'(1);
          pattin_d = idx_q + PAT_W'(1);
        end
      end

      ST_DONE: begin
        pass_d  = (sig_q == GOLDEN);
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        pattin_d = '0;
      end
    endcase
  end

  // Registered status flags decoded from the upcoming state.
  always_comb begin
    busy_d = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State register with synchronous reset that wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pattin_q <= '0;
      cnt_q    <= '0;
      sig_q    <= '0;
      npat_q   <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pattin_q <= pattin_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      npat_q   <= npat_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pattin    = pattin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_count = npat_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_bist_ctrl
// Description : Self-checking bench for pattern_bist_ctrl. A table-driven gate
//               model answers each pattern; expected cycle-by-cycle outputs
//               come from run timing arithmetic and a MISR reference function.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_bist_ctrl;

  localparam int N = 4;   // 2**PAT_W patterns with PAT_W = 2

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0;
  logic [1:0] pattin, pattin0;
  logic       dut_out, dut_en, dut_out0, dut_en0;
  logic       busy, done, pass, busy0, done0, pass0;
  logic [7:0] signature, signature0;
  logic [2:0] pat_count, pat_count0;

  // Gate behaviour as truth tables indexed by the applied pattern.
  logic [N-1:0] en_tab;
  logic [N-1:0] out_tab;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dut_en   = en_tab[pattin];
  assign dut_out  = out_tab[pattin];
  assign dut_en0  = en_tab[pattin0];
  assign dut_out0 = out_tab[pattin0];

  pattern_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pattin(pattin),
    .dut_out(dut_out), .dut_en(dut_en), .busy(busy), .done(done),
    .pass(pass), .signature(signature), .pat_count(pat_count)
  );

  pattern_bist_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pattin(pattin0),
    .dut_out(dut_out0), .dut_en(dut_en0), .busy(busy0), .done(done0),
    .pass(pass0), .signature(signature0), .pat_count(pat_count0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signature after the first n patterns have been captured.
  function automatic logic [7:0] sig_after(input int n);
    int s;
    int resp;
    s = 0;
    for (int p = 0; p < n; p++) begin
      resp = 2 * int'(en_tab[p]) + int'(en_tab[p] & out_tab[p]);
      s = (s >= 128) ? (((s * 2) % 256) ^ 'h1D) : ((s * 2) % 256);
      s = s ^ resp;
    end
    return 8'(s);
  endfunction

  // Good notif0: o = ~a when ctl = 0, else high-Z (data line left floating high).
  task automatic set_notif0();
    for (int i = 0; i < N; i++) begin
      en_tab[i]  = (i % 2) == 0;
      out_tab[i] = ((i % 2) == 0) ? !((i / 2) % 2 == 1) : 1'b1;
    end
  endtask

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start0 = v;
    else     start  = v;
  endtask

  // One full run. Called at a negedge with the selected DUT in IDLE; returns
  // at a negedge with it in IDLE (or, if hold, in the IDLE cycle that starts
  // the next run).
  task automatic run_one(input bit sel, input bit noisy, input bit hold, input string nm);
    int         per, last, k;
    logic [7:0] fsig;
    logic       epass;
    logic       b, d, ps;
    logic [1:0] pt;
    logic [7:0] sg;
    logic [2:0] pc;
    per   = sel ? 2 : 3;
    last  = 1 + N * per;
    fsig  = sig_after(N);
    epass = (fsig == 8'h1C);
    drive_start(sel, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      b  = sel ? busy0 : busy;
      d  = sel ? done0 : done;
      ps = sel ? pass0 : pass;
      pt = sel ? pattin0 : pattin;
      sg = sel ? signature0 : signature;
      pc = sel ? pat_count0 : pat_count;
      k  = (c - 1) / per;
      if (k > N) k = N;
      check({nm, ".busy"}, 32'(b), 32'(c <= N * per));
      check({nm, ".done"}, 32'(d), 32'(c == last));
      check({nm, ".pass"}, 32'(ps), (c == last + 1) ? 32'(epass) : 32'd0);
      check({nm, ".sig"},  32'(sg), 32'(sig_after(k)));
      check({nm, ".cnt"},  32'(pc), 32'(k));
      if (c <= N * per) check({nm, ".pattin"}, 32'(pt), 32'(k));
      if (c == last + 1) check({nm, ".pattin_idle"}, 32'(pt), 32'd0);
      if (hold)                         drive_start(sel, 1'b1);
      else if (noisy && c < last)       drive_start(sel, 1'($urandom_range(0, 1)));
      else if (c == last)               drive_start(sel, noisy);
      else                              drive_start(sel, 1'b0);
    end
    if (!hold) begin
      @(negedge clk);
      check({nm, ".idle_busy"}, 32'(sel ? busy0 : busy), 32'd0);
      check({nm, ".idle_done"}, 32'(sel ? done0 : done), 32'd0);
      check({nm, ".idle_pass"}, 32'(sel ? pass0 : pass), 32'(epass));
      check({nm, ".idle_sig"},  32'(sel ? signature0 : signature), 32'(fsig));
      check({nm, ".idle_cnt"},  32'(sel ? pat_count0 : pat_count), 32'(N));
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b1;   // rst must win over a simultaneous start
    start0 = 1'b1;
    set_notif0();
    repeat (3) @(negedge clk);
    check("rst.busy",   32'(busy), 32'd0);
    check("rst.done",   32'(done), 32'd0);
    check("rst.pass",   32'(pass), 32'd0);
    check("rst.sig",    32'(signature), 32'd0);
    check("rst.cnt",    32'(pat_count), 32'd0);
    check("rst.pattin", 32'(pattin), 32'd0);
    check("rst.busy0",  32'(busy0), 32'd0);
    rst    = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    @(negedge clk);

    // Good gate: 03,06,0E,1C, done at T+13, pass.
    run_one(1'b0, 1'b0, 1'b0, "good");
    check("good.final_sig", 32'(signature), 32'h1C);
    check("good.final_pass", 32'(pass), 32'd1);

    // Stuck-at-1 output: 03,05,09,11, fail.
    en_tab  = '1;
    out_tab = '1;
    run_one(1'b0, 1'b0, 1'b0, "stuck1");
    check("stuck1.final_sig", 32'(signature), 32'h11);
    check("stuck1.final_pass", 32'(pass), 32'd0);

    // Good run to set pass, then reset in the second SETTLE cycle.
    set_notif0();
    run_one(1'b0, 1'b0, 1'b0, "pre_rst");
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);       // now in cycle T+5: pattern 1 SETTLE
    check("midrst.busy_before", 32'(busy), 32'd1);
    check("midrst.pattin_before", 32'(pattin), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.busy",   32'(busy), 32'd0);
    check("midrst.done",   32'(done), 32'd0);
    check("midrst.pass",   32'(pass), 32'd0);
    check("midrst.sig",    32'(signature), 32'd0);
    check("midrst.cnt",    32'(pat_count), 32'd0);
    check("midrst.pattin", 32'(pattin), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_one(1'b0, 1'b0, 1'b0, "after_rst");

    // Start toggled randomly while busy, and high in the DONE cycle.
    run_one(1'b0, 1'b1, 1'b0, "noisy");

    // start held high: back-to-back runs.
    run_one(1'b0, 1'b0, 1'b1, "b2b0");
    run_one(1'b0, 1'b0, 1'b1, "b2b1");
    run_one(1'b0, 1'b0, 1'b0, "b2b2");

    // SETTLE = 0 build: two cycles per pattern, done at T+9.
    run_one(1'b1, 1'b0, 1'b0, "settle0");
    check("settle0.final_sig", 32'(signature0), 32'h1C);

    // Random gate behaviours on either build.
    for (int r = 0; r < 8; r++) begin
      en_tab  = 4'($urandom);
      out_tab = 4'($urandom);
      run_one(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
